// File: rtl/shadow_context_engine.sv
// Shadow context engine: spills the interrupt shadow register bank to the
// stack on interrupt entry and refills it on mret, one register per dcache
// transaction, while tracking how many saved contexts are outstanding.
module shadow_context_engine #(
   parameter int XLEN       = 32,
   parameter int NUM_REGS   = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int MAX_NEST   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  save_req_i,
   input  logic                  restore_req_i,
   input  logic [XLEN-1:0]       sp_i,
   output logic                  req_ack_o,
   output logic                  req_err_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [3:0]            nest_level_o,
   output logic [ADDR_WIDTH-1:0] rf_raddr_o,
   input  logic [XLEN-1:0]       rf_rdata_i,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [XLEN-1:0]       rf_wdata_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [XLEN-1:0]       mem_addr_o,
   output logic [XLEN-1:0]       mem_wdata_o,
   output logic [XLEN/8-1:0]     mem_be_o,
   input  logic                  mem_rvalid_i,
   input  logic [XLEN-1:0]       mem_rdata_i,
   input  logic [XLEN-1:0]       chk_addr_i,
   output logic                  chk_hit_o
);

   localparam int                    BSH        = $clog2(XLEN/8);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_REGS-1);
   localparam logic [3:0]            NEST_MAX   = 4'(MAX_NEST);
   localparam logic [XLEN-1:0]       NUM_REGS_X = XLEN'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE,
      SAVE,
      LOAD_REQ,
      LOAD_WAIT
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [XLEN-1:0]         base_q, base_d;
   logic [3:0]              nest_q, nest_d;
   logic                    done_q, done_d;

   logic [XLEN-1:0]         frame_addr;
   logic [XLEN-1:0]         chk_word;
   logic [XLEN-1:0]         base_word;
   logic [XLEN-1:0]         chk_dist;

   // Register idx sits (NUM_REGS-idx) words below the frame top; wraps mod 2^XLEN
   assign frame_addr = base_q - ((NUM_REGS_X - XLEN'(idx_q)) << BSH);

   // A concurrent LSU access hits when its word lies 1..NUM_REGS words below the frame top
   assign chk_word  = chk_addr_i >> BSH;
   assign base_word = base_q >> BSH;
   assign chk_dist  = base_word - chk_word;
   assign chk_hit_o = (state_q != IDLE) && (chk_dist >= XLEN'(1)) && (chk_dist <= NUM_REGS_X);

   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign nest_level_o = nest_q;

   // State, frame cursor, frame base, nest depth and done pulse; reset abandons any frame
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= LAST_IDX;
         base_q  <= '0;
         nest_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         nest_q  <= nest_d;
         done_q  <= done_d;
      end
   end

   // Request acceptance, frame walk from the top register down to 0, and port drive
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      base_d      = base_q;
      nest_d      = nest_q;
      done_d      = 1'b0;
      req_ack_o   = 1'b0;
      req_err_o   = 1'b0;
      rf_raddr_o  = '0;
      rf_we_o     = 1'b0;
      rf_waddr_o  = '0;
      rf_wdata_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;

      case (state_q)
         IDLE: begin
            if (save_req_i) begin
               if (nest_q < NEST_MAX) begin
                  req_ack_o = 1'b1;
                  base_d    = sp_i;
                  idx_d     = LAST_IDX;
                  state_d   = SAVE;
               end else begin
                  req_err_o = 1'b1;
               end
            end else if (restore_req_i) begin
               if (nest_q != 4'd0) begin
                  req_ack_o = 1'b1;
                  base_d    = sp_i;
                  idx_d     = LAST_IDX;
                  state_d   = LOAD_REQ;
               end else begin
                  req_err_o = 1'b1;
               end
            end
         end

         SAVE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = frame_addr;
            mem_be_o    = '1;
            rf_raddr_o  = idx_q;
            mem_wdata_o = rf_rdata_i;
            if (mem_gnt_i) begin
               if (idx_q == '0) begin
                  nest_d  = nest_q + 4'd1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end

         LOAD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = frame_addr;
            mem_be_o   = '1;
            if (mem_gnt_i) begin
               state_d = LOAD_WAIT;
            end
         end

         LOAD_WAIT: begin
            if (mem_rvalid_i) begin
               rf_we_o    = 1'b1;
               rf_waddr_o = idx_q;
               rf_wdata_o = mem_rdata_i;
               if (idx_q == '0) begin
                  nest_d  = nest_q - 4'd1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = LOAD_REQ;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shadow_context_engine.sv
// Testbench for shadow_context_engine: a cycle task acts as bank, dcache and
// monitor; frames are checked against an address/data list derived from the
// frame layout, and nesting against a simple depth counter.
module tb_shadow_context_engine;

   localparam int NUM = 16;
   localparam int MAXN = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } xfer_t;

   typedef struct {
      logic        save;
      logic        restore;
      logic [31:0] sp;
      logic        exp_ack;
      logic        exp_err;
      int          exp_level;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        save_req;
   logic        restore_req;
   logic [31:0] sp;
   logic        req_ack_o, req_err_o, busy_o, done_o;
   logic [3:0]  nest_level_o;
   logic [5:0]  rf_raddr_o, rf_waddr_o;
   logic [31:0] rf_rdata;
   logic        rf_we_o;
   logic [31:0] rf_wdata_o;
   logic        mem_req_o, mem_we_o;
   logic        gnt;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        rvalid;
   logic [31:0] rdata;
   logic [31:0] chk_addr;
   logic        chk_hit_o;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] bank [NUM];
   logic [31:0] mem [logic [31:0]];
   xfer_t       obs_st[$];
   xfer_t       obs_rf[$];
   xfer_t       stall_obs[$];
   int          done_cnt;
   logic        s_ack, s_err, s_done, s_busy, s_req, s_hit;
   logic [3:0]  s_level;
   int          gnt_mode = 0;
   int          rv_mode = 0;
   int          stall_at = -1;
   int          stall_left = 0;
   logic        pend = 1'b0;
   int          pend_wait = 0;
   logic [31:0] pend_addr = '0;
   logic        in_frame = 1'b0;
   logic [31:0] frame_base = 32'h1000;
   int          frame_kind = 0;
   int          chk_mode = 0;
   logic [31:0] chk_fixed = '0;

   shadow_context_engine #(
      .XLEN(32), .NUM_REGS(NUM), .ADDR_WIDTH(6), .MAX_NEST(MAXN)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .save_req_i(save_req), .restore_req_i(restore_req), .sp_i(sp),
      .req_ack_o(req_ack_o), .req_err_o(req_err_o), .busy_o(busy_o),
      .done_o(done_o), .nest_level_o(nest_level_o),
      .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(gnt), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
      .chk_addr_i(chk_addr), .chk_hit_o(chk_hit_o)
   );

   // Combinational shadow bank read port
   assign rf_rdata = bank[rf_raddr_o[3:0]];

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the run wanders off
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, got running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      tests_run++;
      if (act !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // One clock cycle: called just after a falling edge with request inputs set
   task automatic applyStimulus();
      logic [31:0] cw, bw;
      logic        exp_hit;
      if (chk_mode == 0)
         chk_addr = frame_base + 32'd4 - 32'($urandom_range(0, 19)) * 32'd4 + 32'($urandom_range(0, 3));
      else
         chk_addr = chk_fixed;
      #1;
      gnt = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mem_req_o && mem_we_o && stall_left > 0 && obs_st.size() == stall_at) begin
         gnt = 1'b0;
         stall_left--;
         stall_obs.push_back('{mem_addr_o, mem_wdata_o});
      end
      #1;
      s_ack   = req_ack_o;
      s_err   = req_err_o;
      s_done  = done_o;
      s_busy  = busy_o;
      s_req   = mem_req_o;
      s_hit   = chk_hit_o;
      s_level = nest_level_o;
      cw = chk_addr >> 2;
      bw = frame_base >> 2;
      exp_hit = in_frame && (cw >= bw - 32'd16) && (cw <= bw - 32'd1);
      checkOutput("chk_hit", chk_hit_o, exp_hit);
      if (mem_req_o && gnt) begin
         if (mem_we_o) begin
            obs_st.push_back('{mem_addr_o, mem_wdata_o});
            mem[mem_addr_o] = mem_wdata_o;
         end else begin
            pend      = 1'b1;
            pend_wait = (rv_mode == 0) ? 1 : int'($urandom_range(1, 3));
            pend_addr = mem_addr_o;
         end
      end
      if (rf_we_o) begin
         obs_rf.push_back('{32'(rf_waddr_o), rf_wdata_o});
         bank[rf_waddr_o[3:0]] = rf_wdata_o;
      end
      if (done_o) done_cnt++;
      if (in_frame && ((frame_kind == 0 && obs_st.size() == NUM) ||
                       (frame_kind == 1 && obs_rf.size() == NUM)))
         in_frame = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = '0;
      if (pend) begin
         if (pend_wait <= 1) begin
            rvalid = 1'b1;
            rdata  = memRead(pend_addr);
            pend   = 1'b0;
         end else begin
            pend_wait--;
         end
      end
   endtask

   // Issue one request and, if accepted, run the frame and compare it with the layout model
   task automatic runOp(input logic sv, input logic rs, input logic [31:0] spv,
                        output logic ack, output logic err, output int lat);
      xfer_t exp_q[$];
      int    kind;
      logic [31:0] a;
      kind = sv ? 0 : 1;
      for (int i = NUM - 1; i >= 0; i--) begin
         a = spv - 32'(NUM - i) * 32'd4;
         if (kind == 0) exp_q.push_back('{a, bank[i]});
         else           exp_q.push_back('{32'(i), memRead(a)});
      end
      obs_st.delete();
      obs_rf.delete();
      done_cnt    = 0;
      save_req    = sv;
      restore_req = rs;
      sp          = spv;
      applyStimulus();
      ack = s_ack;
      err = s_err;
      save_req    = 1'b0;
      restore_req = 1'b0;
      sp          = $urandom;
      lat = 0;
      if (ack) begin
         frame_base = spv;
         frame_kind = kind;
         in_frame   = 1'b1;
         while (!s_done && lat < 600) begin
            applyStimulus();
            lat++;
         end
         checkOutput("frame_done_seen", s_done, 1'b1);
         if (kind == 0) begin
            checkOutput("store_count", obs_st.size(), NUM);
            for (int i = 0; i < NUM && i < obs_st.size(); i++)
               checkOutput("store_addr_data", {obs_st[i].a, obs_st[i].d}, {exp_q[i].a, exp_q[i].d});
         end else begin
            checkOutput("rf_write_count", obs_rf.size(), NUM);
            for (int i = 0; i < NUM && i < obs_rf.size(); i++)
               checkOutput("rf_idx_data", {obs_rf[i].a, obs_rf[i].d}, {exp_q[i].a, exp_q[i].d});
         end
         applyStimulus();
         checkOutput("done_once", done_cnt, 1);
         in_frame = 1'b0;
      end else begin
         repeat (2) begin
            applyStimulus();
            checkOutput("idle_no_mem_req", {s_req, s_busy}, 2'b00);
         end
      end
   endtask

   vec_t        vecs[$];
   logic        ack, err;
   int          lat;
   int          lvl_model;
   logic [31:0] stack_q[$];

   initial begin
      rst_n = 1'b0; save_req = 1'b0; restore_req = 1'b0; sp = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; chk_addr = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkOutput("reset_outputs_zero",
                  {req_ack_o, req_err_o, busy_o, done_o, nest_level_o, rf_raddr_o, rf_we_o,
                   mem_req_o, mem_we_o, mem_be_o, chk_hit_o},
                  '0);
      checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
      @(negedge clk);

      // Directed save of 0xA0+i at sp 0x1000
      for (int i = 0; i < NUM; i++) bank[i] = 32'hA0 + 32'(i);
      runOp(1'b1, 1'b0, 32'h1000, ack, err, lat);
      checkOutput("save_ack", ack, 1'b1);
      checkOutput("save_first_store", {obs_st[0].a, obs_st[0].d}, {32'hFFC, 32'hAF});
      checkOutput("save_last_store", {obs_st[NUM-1].a, obs_st[NUM-1].d}, {32'hFC0, 32'hA0});
      checkOutput("save_done_cycle", lat, 17);
      checkOutput("save_level", s_level, 4'd1);

      // Directed restore from memory holding 0xB0+i
      for (int i = 0; i < NUM; i++) mem[32'hFC0 + 32'(4 * i)] = 32'hB0 + 32'(i);
      runOp(1'b0, 1'b1, 32'h1000, ack, err, lat);
      checkOutput("restore_ack", ack, 1'b1);
      checkOutput("restore_first_write", {obs_rf[0].a, obs_rf[0].d}, {32'd15, 32'hBF});
      checkOutput("restore_last_write", {obs_rf[NUM-1].a, obs_rf[NUM-1].d}, {32'd0, 32'hB0});
      checkOutput("restore_done_cycle", lat, 2 * NUM + 1);
      checkOutput("restore_level", s_level, 4'd0);

      // Nesting table: limits, priority and LIFO round trips
      vecs.push_back('{1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b1, 0});
      vecs.push_back('{1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1});
      vecs.push_back('{1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 2});
      vecs.push_back('{1'b1, 1'b0, 32'h0000_3000, 1'b1, 1'b0, 3});
      vecs.push_back('{1'b1, 1'b0, 32'h0000_4000, 1'b1, 1'b0, 4});
      vecs.push_back('{1'b1, 1'b0, 32'h0000_5000, 1'b0, 1'b1, 4});
      vecs.push_back('{1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 3});
      vecs.push_back('{1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 2});
      vecs.push_back('{1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1});
      vecs.push_back('{1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 0});
      vecs.push_back('{1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b1, 0});
      foreach (vecs[k]) begin
         for (int i = 0; i < NUM; i++) bank[i] = $urandom;
         runOp(vecs[k].save, vecs[k].restore, vecs[k].sp, ack, err, lat);
         checkOutput("vec_ack_err", {ack, err}, {vecs[k].exp_ack, vecs[k].exp_err});
         checkOutput("vec_level", s_level, 4'(vecs[k].exp_level));
      end

      // Back-pressure: grant held low for 3 cycles on the 5th store
      for (int i = 0; i < NUM; i++) bank[i] = $urandom;
      stall_obs.delete();
      stall_at = 4;
      stall_left = 3;
      runOp(1'b1, 1'b0, 32'h8000, ack, err, lat);
      checkOutput("stall_cycles", stall_obs.size(), 3);
      foreach (stall_obs[k])
         checkOutput("stall_held", {stall_obs[k].a, stall_obs[k].d}, {32'h7FEC, bank[11]});
      checkOutput("stall_latency", lat, NUM + 4);
      checkOutput("stall_level", s_level, 4'd1);
      stall_at = -1;

      // Simultaneous save+restore at level 1 with fixed overlap probes
      obs_st.delete();
      done_cnt = 0;
      save_req = 1'b1; restore_req = 1'b1; sp = 32'h1000;
      applyStimulus();
      checkOutput("both_ack", {s_ack, s_err}, 2'b10);
      save_req = 1'b0; restore_req = 1'b0;
      frame_base = 32'h1000; frame_kind = 0; in_frame = 1'b1;
      chk_mode = 1;
      chk_fixed = 32'hFE0;
      applyStimulus();
      checkOutput("chk_hit_inside", s_hit, 1'b1);
      chk_fixed = 32'h1000;
      applyStimulus();
      checkOutput("chk_hit_top", s_hit, 1'b0);
      chk_mode = 0;
      lat = 0;
      while (!s_done && lat < 600) begin applyStimulus(); lat++; end
      checkOutput("both_done", s_done, 1'b1);
      checkOutput("both_level", s_level, 4'd2);
      in_frame = 1'b0;

      // Reset while the 7th store is on the port
      obs_st.delete();
      save_req = 1'b1; sp = 32'h3000;
      applyStimulus();
      save_req = 1'b0;
      frame_base = 32'h3000; frame_kind = 0; in_frame = 1'b1;
      lat = 0;
      while (obs_st.size() < 6 && lat < 600) begin applyStimulus(); lat++; end
      checkOutput("pre_reset_stores", obs_st.size(), 6);
      rst_n = 1'b0;
      applyStimulus();
      rst_n = 1'b1;
      in_frame = 1'b0;
      pend = 1'b0;
      applyStimulus();
      checkOutput("post_reset_state", {s_req, s_busy, s_level}, 6'd0);
      for (int i = 0; i < NUM; i++) bank[i] = $urandom;
      runOp(1'b1, 1'b0, 32'h2000, ack, err, lat);
      checkOutput("fresh_save_first", obs_st[0].a, 32'h1FFC);
      checkOutput("fresh_save_latency", lat, NUM + 1);
      checkOutput("fresh_save_level", s_level, 4'd1);

      // Randomized traffic against a depth counter and stack of frame tops
      gnt_mode = 1;
      rv_mode = 1;
      lvl_model = 1;
      stack_q.push_back(32'h2000);
      for (int n = 0; n < 30; n++) begin
         int          r;
         logic        sv, rs, e_ack, e_err;
         logic [31:0] spv;
         r  = int'($urandom_range(0, 9));
         sv = (r <= 4) || (r == 9);
         rs = (r >= 5);
         spv = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 8);
         if (!sv && stack_q.size() > 0 && $urandom_range(0, 3) != 0) spv = stack_q[$];
         for (int i = 0; i < NUM; i++) bank[i] = $urandom;
         e_ack = sv ? (lvl_model < MAXN) : (lvl_model > 0);
         e_err = !e_ack;
         runOp(sv, rs, spv, ack, err, lat);
         checkOutput("rand_ack_err", {ack, err}, {e_ack, e_err});
         if (e_ack && sv) begin
            lvl_model++;
            stack_q.push_back(spv);
         end else if (e_ack) begin
            lvl_model--;
            if (stack_q.size() > 0) void'(stack_q.pop_back());
         end
         checkOutput("rand_level", s_level, 4'(lvl_model));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
